// File: rtl/fifo_ast_pkg.sv
// Shared types and constants for the FIFO-to-Avalon-ST line framer.
package fifo_ast_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    STREAM = 2'd1,
    CLEAR  = 2'd2
  } fsm_e;

  localparam int CLEAR_CYCLES = 2;

  // The line-start flag sits directly above the pixel bits of each FIFO word.
  function automatic int sol_bit(input int pixel_width);
    return pixel_width;
  endfunction

endpackage

// File: rtl/ast_skid2.sv
// Two-entry skid buffer between the FIFO read port and the stream output.
module ast_skid2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_occ;
  logic         w_push;
  logic         w_pop;

  // The read-issue logic reserves space, so a full-buffer push is dropped only defensively.
  assign w_push  = i_push & (r_occ != 2'd2);
  assign w_pop   = i_pop & (r_occ != 2'd0);
  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_mem[r_rp];
  assign o_occ   = r_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_occ <= 2'd0;
    end else if (i_flush) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_occ <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/fifo_ast_framer.sv
// Drains the pixel async FIFO and frames one Avalon-ST packet per active line,
// resynchronising on line-start flags and sequencing FIFO flushes.
module fifo_ast_framer import fifo_ast_pkg::*; #(
  parameter int PIXEL_WIDTH = 8,
  parameter int LINE_WORDS  = 1440,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   Enable_in,
  input  logic                   Flush_in,
  input  logic [PIXEL_WIDTH:0]   Fifo_data_in,
  input  logic                   Fifo_empty_in,
  output logic                   Fifo_rden_out,
  output logic                   Fifo_clear_out,
  output logic [PIXEL_WIDTH-1:0] Ast_data_out,
  output logic                   Ast_valid_out,
  input  logic                   Ast_ready_in,
  output logic                   Ast_sop_out,
  output logic                   Ast_eop_out,
  output logic                   Sync_err_out,
  output logic [CNT_WIDTH-1:0]   Pkt_count_out
);

  localparam int SOL_BIT = sol_bit(PIXEL_WIDTH);
  localparam int WCW     = $clog2(LINE_WORDS);
  localparam int CLW     = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [WCW-1:0] LAST = WCW'(LINE_WORDS - 1);

  fsm_e               r_state;
  logic [WCW-1:0]     r_wcnt;
  logic [CLW-1:0]     r_clr_left;
  logic               r_inflight;
  logic               r_run;
  logic               r_sync_err;
  logic [CNT_WIDTH-1:0] r_pkt;

  logic               w_head_valid;
  logic [PIXEL_WIDTH:0] w_head;
  logic [1:0]         w_occ;
  logic               w_head_sol;
  logic               w_clear_busy;
  logic               w_room;
  logic               w_rd_acc;
  logic               w_xfer;
  logic               w_discard;
  logic               w_pop;

  ast_skid2 #(.W(PIXEL_WIDTH + 1)) u_skid (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .i_flush (Flush_in),
    .i_push  (r_inflight & ~Flush_in),
    .i_data  (Fifo_data_in),
    .i_pop   (w_pop),
    .o_valid (w_head_valid),
    .o_data  (w_head),
    .o_occ   (w_occ)
  );

  assign w_head_sol   = w_head[SOL_BIT];
  assign w_clear_busy = (r_state == CLEAR);
  // Space must exist for the word already in flight as well as the one being requested.
  assign w_room       = ({1'b0, w_occ} + {2'b00, r_inflight}) < 3'd2;
  assign Fifo_rden_out = r_run & Enable_in & ~Flush_in & ~w_clear_busy & w_room;
  assign w_rd_acc     = Fifo_rden_out & ~Fifo_empty_in;

  assign Ast_valid_out = (r_state == STREAM) & w_head_valid;
  assign w_xfer        = Ast_valid_out & Ast_ready_in & ~Flush_in;
  assign w_discard     = (r_state == HUNT) & w_head_valid & ~w_head_sol;
  assign w_pop         = w_xfer | w_discard;

  assign Ast_data_out   = Ast_valid_out ? w_head[PIXEL_WIDTH-1:0] : '0;
  assign Ast_sop_out    = Ast_valid_out & (r_wcnt == '0);
  assign Ast_eop_out    = Ast_valid_out & (r_wcnt == LAST);
  assign Fifo_clear_out = w_clear_busy;
  assign Sync_err_out   = r_sync_err;
  assign Pkt_count_out  = r_pkt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= HUNT;
      r_wcnt     <= '0;
      r_clr_left <= '0;
      r_inflight <= 1'b0;
      r_run      <= 1'b0;
      r_sync_err <= 1'b0;
      r_pkt      <= '0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_rd_acc;
      if (Flush_in) begin
        r_state    <= CLEAR;
        r_clr_left <= CLW'(CLEAR_CYCLES - 1);
        r_wcnt     <= '0;
      end else begin
        case (r_state)
          HUNT: if (w_head_valid && w_head_sol) begin
            r_state <= STREAM;
            r_wcnt  <= '0;
          end
          STREAM: if (w_xfer) begin
            // Only the opening word of a packet may legitimately carry the line-start flag.
            if (w_head_sol && (r_wcnt != '0)) r_sync_err <= 1'b1;
            if (r_wcnt == LAST) begin
              r_wcnt  <= '0;
              r_pkt   <= r_pkt + CNT_WIDTH'(1);
              r_state <= HUNT;
            end else begin
              r_wcnt <= r_wcnt + WCW'(1);
            end
          end
          CLEAR: begin
            if (r_clr_left == '0) r_state <= HUNT;
            else r_clr_left <= r_clr_left - CLW'(1);
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_ast_framer.sv
// Directed bench: a behavioural FIFO plus a word-stream framing model that predicts every beat.
module tb_fifo_ast_framer;

  localparam int PW = 8;
  localparam int LW = 4;
  localparam int CW = 2;

  typedef struct {
    logic [PW-1:0] d;
    bit            sop;
    bit            eop;
  } beat_t;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Enable_in = 1'b1;
  logic          Flush_in = 1'b0;
  logic [PW:0]   Fifo_data_in;
  logic          Fifo_empty_in;
  logic          Fifo_rden_out;
  logic          Fifo_clear_out;
  logic [PW-1:0] Ast_data_out;
  logic          Ast_valid_out;
  logic          Ast_ready_in = 1'b1;
  logic          Ast_sop_out;
  logic          Ast_eop_out;
  logic          Sync_err_out;
  logic [CW-1:0] Pkt_count_out;

  fifo_ast_framer #(.PIXEL_WIDTH(PW), .LINE_WORDS(LW), .CNT_WIDTH(CW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Enable_in(Enable_in), .Flush_in(Flush_in),
    .Fifo_data_in(Fifo_data_in), .Fifo_empty_in(Fifo_empty_in), .Fifo_rden_out(Fifo_rden_out),
    .Fifo_clear_out(Fifo_clear_out), .Ast_data_out(Ast_data_out), .Ast_valid_out(Ast_valid_out),
    .Ast_ready_in(Ast_ready_in), .Ast_sop_out(Ast_sop_out), .Ast_eop_out(Ast_eop_out),
    .Sync_err_out(Sync_err_out), .Pkt_count_out(Pkt_count_out)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_mis = 0;

  // Behavioural FIFO with one-cycle read latency and synchronous clear.
  logic [PW:0] f_mem [256];
  int          f_wr = 0;
  int          f_rd = 0;
  logic [PW:0] f_dout;
  int          n_rd = 0;
  assign Fifo_empty_in = (f_rd == f_wr);
  assign Fifo_data_in  = f_dout;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      f_rd   <= f_wr;
      f_dout <= '0;
    end else if (Fifo_clear_out) begin
      f_rd <= f_wr;
    end else if (Fifo_rden_out && !Fifo_empty_in) begin
      f_dout <= f_mem[f_rd];
      f_rd   <= f_rd + 1;
      n_rd   <= n_rd + 1;
    end
  end

  // Framing model: every word pushed into the FIFO is classified as junk or a predicted beat.
  beat_t exp_q[$];
  bit    m_in = 0;
  int    m_pos = 0;
  bit    exp_err = 0;
  int    exp_pkt = 0;
  int    n_beats = 0;
  logic [PW-1:0] log_d[$];
  bit    log_s[$];
  bit    log_e[$];
  bit    chk_occ = 0;
  int    occ_base = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit sol, input logic [PW-1:0] px);
    beat_t b;
    f_mem[f_wr & 255] = {sol, px};
    f_wr = f_wr + 1;
    if (!m_in) begin
      if (sol) begin
        b.d = px; b.sop = 1; b.eop = 0;
        exp_q.push_back(b);
        m_in = 1;
        m_pos = 1;
      end
    end else begin
      if (sol) exp_err = 1;
      m_pos++;
      b.d = px; b.sop = 0; b.eop = (m_pos == LW);
      exp_q.push_back(b);
      if (m_pos == LW) m_in = 0;
    end
  endtask

  task automatic push_line(input logic [PW-1:0] base);
    for (int i = 0; i < LW; i++) push(i == 0, base + PW'(i));
  endtask

  // Compare process: one check per transfer plus hold-stability and read-ahead bounds.
  bit            hold = 0;
  logic [PW-1:0] h_d;
  bit            h_s, h_e;

  always @(negedge Clk) begin
    beat_t e;
    if (!Reset_n) begin
      exp_pkt = 0;
      hold = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", Ast_valid_out, 1);
        chk("hold_data", Ast_data_out, h_d);
        chk("hold_sop_eop", {Ast_sop_out, Ast_eop_out}, {h_s, h_e});
      end
      if (chk_occ) begin
        n_vec++;
        if (n_rd - n_beats - occ_base > 2) begin
          n_mis++;
          $display("FAIL read_ahead: outstanding %0d expected <= 2", n_rd - n_beats - occ_base);
        end
      end
      if (Ast_valid_out && Ast_ready_in && !Flush_in) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL unexpected_beat: got data %0h sop %0b eop %0b expected none",
                   Ast_data_out, Ast_sop_out, Ast_eop_out);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", Ast_data_out, e.d);
          chk("beat_sop", Ast_sop_out, e.sop);
          chk("beat_eop", Ast_eop_out, e.eop);
          if (e.eop) exp_pkt++;
        end
        n_beats++;
        log_d.push_back(Ast_data_out);
        log_s.push_back(Ast_sop_out);
        log_e.push_back(Ast_eop_out);
      end
      hold = Ast_valid_out && !Ast_ready_in && !Flush_in;
      h_d = Ast_data_out; h_s = Ast_sop_out; h_e = Ast_eop_out;
    end
  end

  task automatic drain(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (exp_q.size() == 0 && !Ast_valid_out && Fifo_empty_in) begin
        chk({name, "_pkt"}, Pkt_count_out, exp_pkt % (1 << CW));
        chk({name, "_err"}, Sync_err_out, exp_err);
        return;
      end
    end
    n_vec++;
    n_mis++;
    $display("FAIL %s_timeout: got %0d beats pending expected 0", name, exp_q.size());
  endtask

  task automatic wait_beats(input int target);
    for (int i = 0; i < 100; i++) begin
      @(posedge Clk); #1;
      if (n_beats >= target) return;
    end
    n_vec++;
    n_mis++;
    $display("FAIL beat_wait: got %0d beats expected %0d", n_beats, target);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (Ast_valid_out) return;
    end
    n_vec++;
    n_mis++;
    $display("FAIL valid_wait: got valid 0 expected 1");
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_valid"}, Ast_valid_out, 0);
    chk({name, "_sop"}, Ast_sop_out, 0);
    chk({name, "_eop"}, Ast_eop_out, 0);
    chk({name, "_data"}, Ast_data_out, 0);
    chk({name, "_rden"}, Fifo_rden_out, 0);
    chk({name, "_clear"}, Fifo_clear_out, 0);
    chk({name, "_err"}, Sync_err_out, 0);
    chk({name, "_pkt"}, Pkt_count_out, 0);
  endtask

  initial begin
    int b;
    int nclr;
    bit ready_pat [6];
    ready_pat = '{1, 0, 0, 1, 0, 1};

    #1 check_all_zero("reset");
    #13 Reset_n = 1'b1;
    @(posedge Clk); #1;

    // Basic line: sop on first word, eop on fourth.
    b = log_d.size();
    push_line(8'h10);
    drain("line1");
    chk("line1_first", log_d[b], 8'h10);
    chk("line1_sop", log_s[b], 1);
    chk("line1_last", log_d[b+3], 8'h13);
    chk("line1_eop", log_e[b+3], 1);
    chk("line1_pkt_lit", Pkt_count_out, 1);

    // Junk ahead of the line-start word is discarded.
    @(posedge Clk); #1;
    b = log_d.size();
    push(0, 8'hAA);
    push(0, 8'hBB);
    push_line(8'h20);
    drain("junk");
    chk("junk_first", log_d[b], 8'h20);
    chk("junk_sop", log_s[b], 1);
    chk("junk_pkt_lit", Pkt_count_out, 2);

    // Backpressure pattern with read-ahead bounded by the skid buffer.
    @(posedge Clk); #1;
    occ_base = n_rd - n_beats;
    chk_occ = 1;
    Ast_ready_in = 1'b0;
    push_line(8'h30);
    wait_valid();
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk); #1;
      Ast_ready_in = ready_pat[i];
    end
    @(posedge Clk); #1;
    Ast_ready_in = 1'b1;
    drain("bp");
    chk_occ = 0;

    // Line-start flag on the third word: data plus sticky error, full length; count wraps.
    @(posedge Clk); #1;
    b = log_d.size();
    push(1, 8'h40);
    push(0, 8'h41);
    push(1, 8'h42);
    push(0, 8'h43);
    drain("midsol");
    chk("midsol_data", log_d[b+2], 8'h42);
    chk("midsol_nosop", log_s[b+2], 0);
    chk("midsol_eop", log_e[b+3], 1);
    chk("midsol_err_lit", Sync_err_out, 1);
    chk("midsol_wrap_lit", Pkt_count_out, 0);

    // Flush after two beats: two clear cycles, no eop, count unchanged.
    @(posedge Clk); #1;
    b = n_beats;
    push_line(8'h50);
    wait_beats(b + 2);
    Flush_in = 1'b1;
    @(posedge Clk); #1;
    Flush_in = 1'b0;
    exp_q.delete();
    m_in = 0;
    nclr = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (Fifo_clear_out) nclr++;
    end
    chk("flush_clear_cycles", nclr, 2);
    chk("flush_pkt_lit", Pkt_count_out, 0);
    chk("flush_beats", n_beats, b + 2);
    @(posedge Clk); #1;
    b = log_d.size();
    push_line(8'h58);
    drain("post_flush");
    chk("post_flush_first", log_d[b], 8'h58);
    chk("post_flush_sop", log_s[b], 1);
    chk("post_flush_pkt_lit", Pkt_count_out, 1);
    chk("err_sticky_lit", Sync_err_out, 1);

    // Asynchronous reset mid-packet.
    @(posedge Clk); #1;
    b = n_beats;
    push_line(8'h60);
    wait_beats(b + 2);
    #2 Reset_n = 1'b0;
    #1 check_all_zero("async_rst");
    exp_q.delete();
    m_in = 0;
    exp_err = 0;
    @(negedge Clk);
    @(negedge Clk);
    #2 Reset_n = 1'b1;
    @(posedge Clk); #1;
    b = log_d.size();
    push_line(8'h70);
    drain("post_rst");
    chk("post_rst_first", log_d[b], 8'h70);
    chk("post_rst_sop", log_s[b], 1);
    chk("post_rst_pkt_lit", Pkt_count_out, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/fifo_ast_framer.md
Name: fifo_ast_framer

Overview:
- Read-side controller for the pixel async FIFO in the BT.656-to-Avalon-ST path.
- Drains FIFO words in the FIFO read-clock domain and frames them into fixed-length Avalon-ST packets (one packet per active video line).
- Handles the FIFO's one-cycle read latency, downstream backpressure, resynchronisation on line-start markers, and FIFO flush sequencing.

Parameters:
- PIXEL_WIDTH, 8, pixel data width; each FIFO word is {sol_flag, pixel[PIXEL_WIDTH-1:0]}.
- LINE_WORDS, 1440, words per packet; must be >= 2.
- CNT_WIDTH, 16, width of the packet counter.

Ports:
- Clk  in  1  FIFO read clock; all logic rises on this edge.
- Reset_n  in  1  asynchronous active-low reset.
- Enable_in  in  1  0 = no new FIFO reads; an open packet still completes.
- Flush_in  in  1  one-cycle request to abort and clear the FIFO.
- Fifo_data_in  in  PIXEL_WIDTH+1  FIFO Data_out; valid the cycle after an accepted read.
- Fifo_empty_in  in  1  FIFO Empty flag.
- Fifo_rden_out  out  1  FIFO ReadEn.
- Fifo_clear_out  out  1  FIFO Clear (synchronous, active-high).
- Ast_data_out  out  PIXEL_WIDTH  stream data.
- Ast_valid_out  out  1  stream valid.
- Ast_ready_in  in  1  stream ready; readyLatency 0.
- Ast_sop_out  out  1  startofpacket.
- Ast_eop_out  out  1  endofpacket.
- Sync_err_out  out  1  sticky flag: sol_flag seen mid-packet.
- Pkt_count_out  out  CNT_WIDTH  count of completed packets (eop transferred); wraps.

Behaviour:
- Reset: all outputs 0, FSM = HUNT, skid buffer empty, word counter 0.
- Read issue:
  - A read is accepted when Fifo_rden_out & ~Fifo_empty_in.
  - Fifo_rden_out = Enable_in & ~Flush_in & ~clear_busy & (skid_occupancy + inflight < 2).
  - inflight = 1 the cycle after an accepted read.
  - The returned word is captured next cycle into the 2-entry skid buffer; it is never lost under backpressure.
- Transfer: a stream beat completes when Ast_valid_out & Ast_ready_in. Data, sop and eop are held stable while valid & ~ready.
- FSM:
  - HUNT: pop words from the skid buffer and discard them (no valid) until the head word has sol_flag = 1. That word is presented with sop = 1; go to STREAM with the counter at 0.
  - STREAM: on each transfer, counter += 1. The word at counter == LINE_WORDS-1 carries eop = 1. On its transfer: Pkt_count_out += 1, counter cleared, go to HUNT.
  - Mid-packet sol_flag: the word is emitted as ordinary data (no sop), Sync_err_out is set and stays set until reset, and the packet runs to its full length.
  - sol_flag on the eop word: treated the same as mid-packet (data plus error). The next packet then needs a fresh sol word.
- sop and eop are never asserted on the same beat, since LINE_WORDS >= 2.
- Flush:
  - Flush_in (any state) drops skid contents and any inflight word, asserts Fifo_clear_out for exactly 2 cycles (clear_busy), then returns to HUNT.
  - An open packet is abandoned without eop; Pkt_count_out is unchanged.
  - Flush_in during clear_busy restarts the 2-cycle clear.
  - Flush has priority over a same-cycle transfer: that beat is not counted.
- Enable_in low mid-packet: reads already in flight still land. No new reads until Enable_in returns; valid drops when the skid buffer drains.
- FIFO empty mid-packet: valid deasserts; the packet resumes when data returns. Gaps are legal.
- Counter widths: word counter sized $clog2(LINE_WORDS). Pkt_count_out wraps from 2^CNT_WIDTH-1 to 0.

Decomposition:
- Package fifo_ast_pkg: FSM state enum (HUNT, STREAM, CLEAR), SOL_BIT index (= PIXEL_WIDTH), CLEAR_CYCLES = 2.
- One sub-module, ast_skid2: 2-entry valid/ready skid buffer with occupancy output. The controller FSM, counters and read issue logic stay in fifo_ast_framer.

Test Plan:
- LINE_WORDS=4, ready tied 1, FIFO pre-loaded with {1,0x10},{0,0x11},{0,0x12},{0,0x13} -> 4 beats: 0x10 with sop, 0x13 with eop; Pkt_count_out = 1; Sync_err_out = 0.
- Junk words 0xAA, 0xBB (flag 0) ahead of a sol word 0x20 -> junk never valid; first beat is 0x20 with sop.
- Ready toggles 1,0,0,1,0,1 during a packet -> data order intact, no duplicated or dropped word, FIFO reads stall when the skid buffer is full, eop on the 4th transfer.
- sol_flag on the 3rd word of a packet -> emitted without sop, Sync_err_out = 1 and stays 1, packet length still 4.
- Flush_in after 2 beats of a packet -> Fifo_clear_out high exactly 2 cycles, no eop, Pkt_count_out unchanged, next sol word starts a clean packet.
- Reset_n pulsed low mid-packet, asynchronously to Clk -> all outputs 0 immediately, FSM in HUNT after release.
